mem_access_unit: RTL
====================

# mem_access_unit

Parametrised successor to the pipeline's MEM stage: serves load/store requests from EX/MEM against an internal data array, with a valid/ready handshake and configurable wait states. Supports byte, halfword and word accesses with sign or zero extension, little-endian byte lanes, and alignment checking. Sits between the EX/MEM and MEM/WB pipeline registers. While busy it holds `req_ready` low, which the hazard unit uses to stall the pipeline.

## Interface

- `DATA_W`, 32: data and address width; fixed at 32 for this generation.
- `DEPTH_WORDS`, 256: array depth in words; power of two.
- `WAIT_STATES`, 2: extra cycles per access; 0 is legal.
- `PRELOAD_ADDR`, 80: byte address of the word initialised at power-up.
- `PRELOAD_VAL`, 100: power-up value of that word.

Ports (name, direction, width, meaning):

- `clk`  in  1  single clock; all state is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  zero-extend loads when 1; sign-extend when 0.
- `alu_result`  in  32  byte address.
- `reg2_data`  in  32  store data; uses the low bytes for sub-word stores.
- `resp_valid`  out  1  one-cycle response strobe.
- `mem_data_out`  out  32  extended load data.
- `alu_result_out`  out  32  latched request address, passed to WB.
- `access_err`  out  1  misaligned or illegal-size request; valid with `resp_valid`.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid` is high, latch the write flag, size, unsigned flag, address and store data.
  - Go to WAIT if `WAIT_STATES`>0, otherwise go to RESP.
- WAIT:
  - A down-counter loaded with `WAIT_STATES`-1 decrements each cycle.
  - At 0, go to RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then go to IDLE.
  - `req_ready`=0 in both WAIT and RESP.
- The access is performed on the edge that enters RESP:
  - Stores update the array on that edge.
  - Loads register `mem_data_out` on that edge.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH_WORDS`*4.
- Byte lanes are little-endian:
  - Byte access selects lane `addr[1:0]`.
  - Halfword access selects bytes `addr[1]*2` and `addr[1]*2+1`.
  - Stores write only the selected lanes; the other bytes in the word are unchanged.
- Loads extend to 32 bits:
  - `req_unsigned`=1: zero-extend.
  - `req_unsigned`=0: sign-extend from bit 7 (byte) or bit 15 (halfword).
  - Word loads are not extended.
- Error conditions: halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or `req_size`=11. On error:
  - `access_err`=1 and the array is not written.
  - `mem_data_out`=0.
  - Latency is unchanged.
- `mem_data_out`, `alu_result_out` and `access_err` hold their values until the next response. A store response drives `mem_data_out`=0.
- Array contents are not reset. Power-up contents are zero, except the word at `PRELOAD_ADDR`, which holds `PRELOAD_VAL`.

## Timing

- Edge E0 is the edge where `req_valid` and `req_ready` are both high.
- `resp_valid` rises at E0+`WAIT_STATES`+1 and falls one edge later.
- `req_ready` returns high at E0+`WAIT_STATES`+2. Maximum throughput is one request per `WAIT_STATES`+2 cycles.
- `req_valid` high while `req_ready`=0 is ignored; it is not queued.
- A load issued after a store to the same address returns the stored data, because the store commits before `req_ready` rises.
- `reset_n` low, at any time including mid-access:
  - State goes to IDLE and the counter clears.
  - A pending store is discarded.
  - `req_ready`=1; `resp_valid`=0; `mem_data_out`=0; `alu_result_out`=0; `access_err`=0.
- First acceptance is possible at the first rising edge after `reset_n` deasserts.

## Test plan

- Reset, then word load at 80 with `WAIT_STATES`=2 → `resp_valid` at E0+3, `mem_data_out`=100, `alu_result_out`=80, `access_err`=0.
- Word store of 123 at 4, then word load at 4 → `mem_data_out`=123. Check `req_ready`=0 for 3 cycles after each acceptance and that `req_valid` held high during that time is ignored.
- Byte store 0xAB at 6, then:
  - signed byte load at 6 → 0xFFFFFFAB;
  - unsigned byte load at 6 → 0x000000AB;
  - word load at 4 → 0x00AB007B.
- Halfword store 0x8001 at 2, then signed halfword load at 2 → 0xFFFF8001; unsigned → 0x00008001.
- Word store at address 2, then word load at 0 → first response `access_err`=1 with `mem_data_out`=0; the load at 0 shows the word unchanged. Repeat with `req_size`=11 → `access_err`=1.
- Store 0x55 to 8, then assert `reset_n` low one cycle after acceptance → all outputs are at reset values and a word load at 8 returns the old value. Also run address 4+`DEPTH_WORDS`*4 → it aliases to 4 (wrap-around).

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: valid/ready request port, configurable wait states,
// byte/halfword/word access with sign/zero extension and alignment checking.
module mem_access_unit #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned WAIT_STATES  = 2,
  parameter int unsigned PRELOAD_ADDR = 80,
  parameter int unsigned PRELOAD_VAL  = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] reg2_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic              access_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned CW        = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit          HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [AW-1:0] PRE_IDX = AW'((PRELOAD_ADDR >> 2) % DEPTH_WORDS);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_write, r_unsigned;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_addr, r_wdata;
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  logic              w_access, w_write, w_unsigned, w_err;
  logic [1:0]        w_size;
  logic [DATA_W-1:0] w_addr, w_sdata, w_key, w_rword, w_load, w_wdata;
  logic [AW-1:0]     w_idx;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_be;

  // With no wait states the access happens on the accepting edge, so use the live request.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_write    = req_write;
      w_size     = req_size;
      w_unsigned = req_unsigned;
      w_addr     = alu_result;
      w_sdata    = reg2_data;
    end else begin
      w_write    = r_write;
      w_size     = r_size;
      w_unsigned = r_unsigned;
      w_addr     = r_addr;
      w_sdata    = r_wdata;
    end
  end

  assign w_idx = w_addr[AW+1:2];
  assign w_err = (w_size == 2'b11) || (w_size == 2'b01 && w_addr[0]) ||
                 (w_size == 2'b10 && w_addr[1:0] != 2'b00);

  // Words are stored XORed with a per-index key so zero power-up state reads back the preload word.
  assign w_key   = (w_idx == PRE_IDX) ? DATA_W'(PRELOAD_VAL) : '0;
  assign w_rword = r_mem[w_idx] ^ w_key;
  assign w_byte  = w_rword[{w_addr[1:0], 3'b000} +: 8];
  assign w_half  = w_rword[{w_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load  = w_rword;
    w_be    = 4'b0000;
    w_wdata = w_sdata;
    case (w_size)
      2'b00: begin
        w_load  = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{w_sdata[7:0]}};
      end
      2'b01: begin
        w_load  = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_sdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    req_ready   = (r_state == S_IDLE);
    resp_valid  = (r_state == S_RESP);
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (HAS_WAIT) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_RESP;
            w_access    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_access    = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_write        <= 1'b0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      mem_data_out   <= '0;
      alu_result_out <= '0;
      access_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && req_valid) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= alu_result;
        r_wdata    <= reg2_data;
        r_cnt      <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) begin
        alu_result_out <= w_addr;
        access_err     <= w_err;
        mem_data_out   <= (w_err || w_write) ? '0 : w_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_access && w_write && !w_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8] ^ w_key[b*8 +: 8];
      end
    end
  end

endmodule
